// File: rtl/parallella_gpio_filter_pkg.sv
// -----------------------------------------------------------------------------
// parallella_gpio_pkg
// Shared definitions for the Parallella GPIO input-conditioning stage:
//   - default pin count and debounce counter width
//   - number of clock cycles spent flushing the synchroniser after reset
//   - 2-bit encoding of the FILL0 -> FILL1 -> LOAD -> RUN start-up sequence
// -----------------------------------------------------------------------------
package parallella_gpio_pkg;

  localparam int unsigned NSIGS_DEF = 32'd48;
  localparam int unsigned CNT_W_DEF = 32'd16;

  // Cycles needed to push the first real pad sample through the two sync flops.
  localparam int unsigned FILL_LEN  = 32'd2;

  // The encoding counts through the fill cycles, so LOAD sits right after them.
  typedef enum logic [1:0] {
    ST_FILL0 = 2'd0,
    ST_FILL1 = 2'd1,
    ST_LOAD  = 2'(FILL_LEN),
    ST_RUN   = 2'd3
  } gpio_state_e;

endpackage : parallella_gpio_pkg

// File: rtl/parallella_gpio_filter_if.sv
// -----------------------------------------------------------------------------
// parallella_gpio_filter_if
// Bundle of the GPIO conditioning data/control signals.
//   gpio_raw_i    : asynchronous pad inputs (IOBUF O outputs)
//   debounce_len  : extra stable cycles before the filtered value may change
//   rise_en       : per-pin rising-edge event enable
//   fall_en       : per-pin falling-edge event enable
//   evt_clr       : write-1-to-clear strobe for the pending bits
//   gpio_filt_o   : conditioned value towards the PS EMIO GPIO input bus
//   evt_pending_o : sticky edge-event bits
//   irq_o         : level interrupt, OR of the pending bits
// modport master : side that drives pads/controls and observes results
// modport slave  : the filter itself
// -----------------------------------------------------------------------------
interface parallella_gpio_filter_if
  import parallella_gpio_pkg::*;
#(
  parameter int NSIGS = NSIGS_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [NSIGS-1:0] gpio_raw_i;
  logic [CNT_W-1:0] debounce_len;
  logic [NSIGS-1:0] rise_en;
  logic [NSIGS-1:0] fall_en;
  logic [NSIGS-1:0] evt_clr;
  logic [NSIGS-1:0] gpio_filt_o;
  logic [NSIGS-1:0] evt_pending_o;
  logic             irq_o;

  modport master (
    output gpio_raw_i, debounce_len, rise_en, fall_en, evt_clr,
    input  gpio_filt_o, evt_pending_o, irq_o
  );

  modport slave (
    input  gpio_raw_i, debounce_len, rise_en, fall_en, evt_clr,
    output gpio_filt_o, evt_pending_o, irq_o
  );

endinterface : parallella_gpio_filter_if

// File: rtl/parallella_gpio_filter_debounce.sv
// -----------------------------------------------------------------------------
// parallella_gpio_debounce
// One GPIO pin: two-flop synchroniser, stable-count debounce and filtered value.
//   clk, reset     : block clock, synchronous active-high reset
//   raw_i          : asynchronous pad input
//   debounce_len_i : extra stable cycles required (0 = no filtering)
//   load_i         : parent is in LOAD, copy the synchroniser output directly
//   run_i          : parent is in RUN, normal filtering
//   filt_o         : filtered value (registered)
//   rise_o, fall_o : single-cycle pulses, asserted in the cycle before the edge
//                    on which filt_o changes to 1 / to 0
// Build option GPIO_DEBOUNCE_EN: when defined the per-pin counter is built;
// otherwise filt follows the synchroniser every RUN cycle and debounce_len_i
// is ignored.
// -----------------------------------------------------------------------------
module parallella_gpio_debounce
  import parallella_gpio_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_i,
  input  logic [CNT_W-1:0] debounce_len_i,
  input  logic             load_i,
  input  logic             run_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic filt_q, filt_d;
  logic update_s;

`ifdef GPIO_DEBOUNCE_EN

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser shift, stable-count filter and update detection.
  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    update_s = 1'b0;
    if (load_i) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else if (run_i) begin
      if (s2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q < debounce_len_i) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        // Also covers a count left above a freshly lowered debounce_len.
        filt_d   = s2_q;
        cnt_d    = '0;
        update_s = 1'b1;
      end
    end else begin
      // Synchroniser still flushing: hold everything at its idle value.
      filt_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`else

  // Only the reduction keeps the unused length input visible to lint.
  logic unused_len_s;
  assign unused_len_s = ^debounce_len_i;

  // Synchroniser shift; filt follows the synchroniser once LOAD is reached.
  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    filt_d   = 1'b0;
    update_s = 1'b0;
    if (load_i || run_i) begin
      filt_d   = s2_q;
      update_s = run_i & (s2_q ^ filt_q);
    end else begin
      filt_d   = 1'b0;
      update_s = 1'b0;
    end
  end

`endif

  // Synchroniser and filtered-value registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = update_s & s2_q;
  assign fall_o = update_s & ~s2_q;

endmodule : parallella_gpio_debounce

// File: rtl/parallella_gpio_filter.sv
// -----------------------------------------------------------------------------
// parallella_gpio_filter
// Input-conditioning stage between the GPIO pad buffers and the PS EMIO GPIO
// input bus: synchronise, debounce, detect edges, latch sticky events, raise a
// level interrupt.
//   clk   : block clock
//   reset : synchronous active-high reset
//   bus   : parallella_gpio_filter_if.slave (pads, controls, filtered value,
//           pending bits, irq)
// Build option GPIO_DEBOUNCE_EN selects the counter-based debounce inside
// parallella_gpio_debounce; without it the filter is a fixed 3-edge pipeline.
// -----------------------------------------------------------------------------
module parallella_gpio_filter
  import parallella_gpio_pkg::*;
#(
  parameter int NSIGS = NSIGS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  parallella_gpio_filter_if.slave  bus
);

  gpio_state_e      state_q, state_d;
  logic             run_s;
  logic             load_s;
  logic [NSIGS-1:0] filt_s;
  logic [NSIGS-1:0] rise_s;
  logic [NSIGS-1:0] fall_s;
  logic [NSIGS-1:0] set_s;
  logic [NSIGS-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;

  // Start-up sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL0;
    end else begin
      state_q <= state_d;
    end
  end

  // Start-up sequencer next state and pin qualifiers.
  always_comb begin
    state_d = state_q;
    run_s   = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_FILL0: state_d = ST_FILL1;
      ST_FILL1: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_RUN;
        load_s  = 1'b1;
      end
      ST_RUN: begin
        state_d = ST_RUN;
        run_s   = 1'b1;
      end
      default: state_d = ST_FILL0;
    endcase
  end

  for (genvar i = 0; i < NSIGS; i++) begin : g_pin
    parallella_gpio_debounce #(
      .CNT_W(CNT_W)
    ) u_deb (
      .clk            (clk),
      .reset          (reset),
      .raw_i          (bus.gpio_raw_i[i]),
      .debounce_len_i (bus.debounce_len),
      .load_i         (load_s),
      .run_i          (run_s),
      .filt_o         (filt_s[i]),
      .rise_o         (rise_s[i]),
      .fall_o         (fall_s[i])
    );
  end

  // Sticky pending bits: a new event in the clear cycle must not be lost.
  always_comb begin
    set_s  = (rise_s & bus.rise_en) | (fall_s & bus.fall_en);
    pend_d = (pend_q & ~bus.evt_clr) | set_s;
    irq_d  = |pend_q;
  end

  // Pending and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.gpio_filt_o   = filt_s;
  assign bus.evt_pending_o = pend_q;
  assign bus.irq_o         = irq_q;

endmodule : parallella_gpio_filter

// File: tb/tb_parallella_gpio_filter.sv
// -----------------------------------------------------------------------------
// tb_parallella_gpio_filter
// Directed bench for parallella_gpio_filter. Inputs change 1 time unit after a
// rising edge and outputs are read at the same point, so "edge n" below is the
// n-th rising edge after the stimulus change. Expected timings depend on
// whether GPIO_DEBOUNCE_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_parallella_gpio_filter;

  localparam int NS = 48;
  localparam int CW = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  parallella_gpio_filter_if #(.NSIGS(NS), .CNT_W(CW)) bus ();

  parallella_gpio_filter #(.NSIGS(NS), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one pin high for 'width' sampling edges and record, over 'window'
  // edges, when filt/pending/irq first go high and how long filt stays high.
  task automatic observe(input int pin, input int width, input int window,
                         output int first_hi, output int n_hi,
                         output int first_pend, output int first_irq);
    first_hi = 0; n_hi = 0; first_pend = 0; first_irq = 0;
    bus.gpio_raw_i[pin] = 1'b1;
    for (int i = 1; i <= window; i++) begin
      tick();
      if (bus.gpio_filt_o[pin] && first_hi == 0) first_hi = i;
      if (bus.gpio_filt_o[pin]) n_hi++;
      if (bus.evt_pending_o[pin] && first_pend == 0) first_pend = i;
      if (bus.irq_o && first_irq == 0) first_irq = i;
      if (i == width) bus.gpio_raw_i[pin] = 1'b0;
    end
  endtask

  task automatic clear_pend(input string tag);
    bus.evt_clr = '1;
    tick();
    bus.evt_clr = '0;
    tick();
    vectors++;
    if ({bus.evt_pending_o, bus.irq_o} !== {48'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s clear: pend=%h irq=%b, want 0/0", tag, bus.evt_pending_o, bus.irq_o);
    end
  endtask

  task automatic test_reset();
    logic [NS-1:0] pat;
    pat = 48'hFFFF_0000_00FF;
    reset = 1'b1;
    bus.gpio_raw_i = pat; bus.rise_en = '1; bus.fall_en = '1;
    bus.debounce_len = 16'd0; bus.evt_clr = '0;
    tick(); tick();
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o, bus.irq_o} !== {48'h0, 48'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL in_reset: filt=%h pend=%h irq=%b, want all 0", bus.gpio_filt_o, bus.evt_pending_o, bus.irq_o);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.gpio_filt_o !== 48'h0) begin
      miscompares++; $display("FAIL fill_edge1: filt=%h want 0", bus.gpio_filt_o);
    end
    tick();
    vectors++;
    if (bus.gpio_filt_o !== 48'h0) begin
      miscompares++; $display("FAIL fill_edge2: filt=%h want 0", bus.gpio_filt_o);
    end
    tick();
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o} !== {pat, 48'h0}) begin
      miscompares++;
      $display("FAIL load_edge3: filt=%h pend=%h, want %h/0", bus.gpio_filt_o, bus.evt_pending_o, pat);
    end
    tick();
    vectors++;
    if ({bus.evt_pending_o, bus.irq_o} !== {48'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL post_load_irq: pend=%h irq=%b, want 0/0", bus.evt_pending_o, bus.irq_o);
    end
    // Drop the inputs with falling events disabled: nothing may latch.
    bus.fall_en = '0;
    bus.gpio_raw_i = '0;
    repeat (4) tick();
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o} !== {48'h0, 48'h0}) begin
      miscompares++;
      $display("FAIL fall_disabled: filt=%h pend=%h, want 0/0", bus.gpio_filt_o, bus.evt_pending_o);
    end
    bus.rise_en = '0;
  endtask

  task automatic test_patterns();
    logic [NS-1:0] pats [3];
    logic [NS-1:0] prev;
    pats[0] = 48'hA5A5_0F0F_1234;
    pats[1] = 48'h5A5A_F0F0_EDCB;
    pats[2] = 48'h8000_0000_0001;
    prev = '0;
    bus.debounce_len = 16'd0;
    for (int p = 0; p < 3; p++) begin
      bus.gpio_raw_i = pats[p];
      tick(); tick();
      vectors++;
      if (bus.gpio_filt_o !== prev) begin
        miscompares++; $display("FAIL pattern%0d_early: filt=%h want %h", p, bus.gpio_filt_o, prev);
      end
      tick();
      vectors++;
      if (bus.gpio_filt_o !== pats[p]) begin
        miscompares++; $display("FAIL pattern%0d: filt=%h want %h", p, bus.gpio_filt_o, pats[p]);
      end
      prev = pats[p];
    end
    bus.gpio_raw_i = '0;
    repeat (3) tick();
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o} !== {48'h0, 48'h0}) begin
      miscompares++;
      $display("FAIL pattern_zero: filt=%h pend=%h, want 0/0", bus.gpio_filt_o, bus.evt_pending_o);
    end
  endtask

  task automatic test_debounce();
    int fh, nh, fp, fi;
    bus.debounce_len = 16'd4;
    bus.rise_en = 48'h20;
    bus.fall_en = '0;
    observe(5, 4, 14, fh, nh, fp, fi);
    vectors++;
    if ({fh, nh, fp, fi} !== (DEB ? {32'd0, 32'd0, 32'd0, 32'd0} : {32'd3, 32'd4, 32'd3, 32'd4})) begin
      miscompares++;
      $display("FAIL pulse4_pin5: first/len/pend/irq=%0d/%0d/%0d/%0d debounce=%0d", fh, nh, fp, fi, DEB);
    end
    clear_pend("pulse4");
    observe(5, 5, 14, fh, nh, fp, fi);
    vectors++;
    if ({fh, nh, fp, fi} !== (DEB ? {32'd7, 32'd5, 32'd7, 32'd8} : {32'd3, 32'd5, 32'd3, 32'd4})) begin
      miscompares++;
      $display("FAIL pulse5_pin5: first/len/pend/irq=%0d/%0d/%0d/%0d debounce=%0d", fh, nh, fp, fi, DEB);
    end
    clear_pend("pulse5");
    bus.debounce_len = 16'd0;
  endtask

  task automatic test_len0_pin3();
    bus.debounce_len = 16'd0;
    bus.rise_en = 48'h8;
    bus.fall_en = '0;
    bus.gpio_raw_i[3] = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.gpio_filt_o[3] !== 1'b0) begin
      miscompares++; $display("FAIL pin3_rise_early: filt3=%b want 0", bus.gpio_filt_o[3]);
    end
    tick();
    vectors++;
    if ({bus.gpio_filt_o[3], bus.evt_pending_o, bus.irq_o} !== {1'b1, 48'h8, 1'b0}) begin
      miscompares++;
      $display("FAIL pin3_rise: filt3=%b pend=%h irq=%b, want 1/8/0", bus.gpio_filt_o[3], bus.evt_pending_o, bus.irq_o);
    end
    tick();
    vectors++;
    if (bus.irq_o !== 1'b1) begin
      miscompares++; $display("FAIL pin3_irq: irq=%b want 1", bus.irq_o);
    end
    clear_pend("pin3");
    bus.gpio_raw_i[3] = 1'b0;
    tick(); tick();
    vectors++;
    if (bus.gpio_filt_o[3] !== 1'b1) begin
      miscompares++; $display("FAIL pin3_fall_early: filt3=%b want 1", bus.gpio_filt_o[3]);
    end
    tick();
    vectors++;
    if ({bus.gpio_filt_o[3], bus.evt_pending_o} !== {1'b0, 48'h0}) begin
      miscompares++;
      $display("FAIL pin3_fall: filt3=%b pend=%h, want 0/0", bus.gpio_filt_o[3], bus.evt_pending_o);
    end
    tick();
    vectors++;
    if (bus.irq_o !== 1'b0) begin
      miscompares++; $display("FAIL pin3_fall_irq: irq=%b want 0", bus.irq_o);
    end
  endtask

  task automatic test_set_wins();
    bus.rise_en = 48'h80;
    bus.fall_en = '0;
    bus.gpio_raw_i[7] = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.evt_pending_o !== 48'h80) begin
      miscompares++; $display("FAIL pin7_first_rise: pend=%h want 80", bus.evt_pending_o);
    end
    bus.gpio_raw_i[7] = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus.gpio_filt_o[7], bus.evt_pending_o} !== {1'b0, 48'h80}) begin
      miscompares++;
      $display("FAIL pin7_sticky: filt7=%b pend=%h, want 0/80", bus.gpio_filt_o[7], bus.evt_pending_o);
    end
    bus.gpio_raw_i[7] = 1'b1;
    tick(); tick();
    bus.evt_clr = 48'h80;    // lands on the same edge as the new rise
    tick();
    bus.evt_clr = '0;
    vectors++;
    if ({bus.gpio_filt_o[7], bus.evt_pending_o} !== {1'b1, 48'h80}) begin
      miscompares++;
      $display("FAIL set_beats_clear: filt7=%b pend=%h, want 1/80", bus.gpio_filt_o[7], bus.evt_pending_o);
    end
    bus.rise_en = '0;
    tick();
    vectors++;
    if (bus.evt_pending_o !== 48'h80) begin
      miscompares++; $display("FAIL enable_off_keeps_pend: pend=%h want 80", bus.evt_pending_o);
    end
    bus.evt_clr = 48'h80;
    tick();
    bus.evt_clr = '0;
    vectors++;
    if ({bus.evt_pending_o, bus.irq_o} !== {48'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL pin7_clear: pend=%h irq=%b, want 0/1", bus.evt_pending_o, bus.irq_o);
    end
    tick();
    vectors++;
    if (bus.irq_o !== 1'b0) begin
      miscompares++; $display("FAIL pin7_irq_fall: irq=%b want 0", bus.irq_o);
    end
    bus.gpio_raw_i[7] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int pre;
    int len;
    pre = DEB ? 5 : 2;       // with debounce: count has reached 3 of 10
    len = DEB ? 10 : 0;
    bus.debounce_len = 16'd10;
    bus.rise_en = 48'h200;
    bus.fall_en = '0;
    bus.gpio_raw_i = 48'h200;
    repeat (pre) tick();
    vectors++;
    if (bus.gpio_filt_o[9] !== 1'b0) begin
      miscompares++; $display("FAIL pin9_pre_reset: filt9=%b want 0", bus.gpio_filt_o[9]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o, bus.irq_o} !== {48'h0, 48'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: filt=%h pend=%h irq=%b, want 0", bus.gpio_filt_o, bus.evt_pending_o, bus.irq_o);
    end
    tick(); tick();
    vectors++;
    if (bus.gpio_filt_o !== 48'h0) begin
      miscompares++; $display("FAIL mid_reset_fill: filt=%h want 0", bus.gpio_filt_o);
    end
    tick();
    vectors++;
    if ({bus.gpio_filt_o, bus.evt_pending_o} !== {48'h200, 48'h0}) begin
      miscompares++;
      $display("FAIL mid_reset_load: filt=%h pend=%h, want 200/0", bus.gpio_filt_o, bus.evt_pending_o);
    end
    tick();
    vectors++;
    if ({bus.evt_pending_o, bus.irq_o} !== {48'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset_noevt: pend=%h irq=%b, want 0/0", bus.evt_pending_o, bus.irq_o);
    end
    bus.gpio_raw_i = '0;
    repeat (2 + len) tick();
    vectors++;
    if (bus.gpio_filt_o[9] !== 1'b1) begin
      miscompares++; $display("FAIL pin9_fall_early: filt9=%b want 1", bus.gpio_filt_o[9]);
    end
    tick();
    vectors++;
    if (bus.gpio_filt_o[9] !== 1'b0) begin
      miscompares++; $display("FAIL pin9_fall: filt9=%b want 0", bus.gpio_filt_o[9]);
    end
    bus.debounce_len = 16'd0;
  endtask

  task automatic test_short_pulse();
    int fh, nh, fp, fi;
    bus.debounce_len = 16'd100;
    bus.rise_en = 48'h1;
    bus.fall_en = '0;
    observe(0, 1, 8, fh, nh, fp, fi);
    vectors++;
    if ({fh, nh, fp, fi} !== (DEB ? {32'd0, 32'd0, 32'd0, 32'd0} : {32'd3, 32'd1, 32'd3, 32'd4})) begin
      miscompares++;
      $display("FAIL pulse1_pin0: first/len/pend/irq=%0d/%0d/%0d/%0d debounce=%0d", fh, nh, fp, fi, DEB);
    end
    clear_pend("pulse1");
    bus.debounce_len = 16'd0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.gpio_raw_i = '0;
    bus.debounce_len = 16'd0;
    bus.rise_en = '0;
    bus.fall_en = '0;
    bus.evt_clr = '0;
    test_reset();
    test_patterns();
    test_debounce();
    test_len0_pin3();
    test_set_wins();
    test_reset_mid();
    test_short_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_parallella_gpio_filter
